// File: rtl/tcu_tag_dispatch_pkg.sv
// -----------------------------------------------------------------------------
// tcu_tag_dispatch_pkg
// Shared types and constants for the TQU -> TCU egress tag dispatcher.
//   - slot_t      : contents of the single registered output slot {port, tag, eop}
//   - state_e     : dispatcher FSM states (ARB, LOCK)
//   - credit_width: width of a counter able to hold 0..credit_max
//   - STAT_CNT_W  : width of each per-port packet statistics counter
// slot_t is sized for the default geometry (4 ports, 32-bit tags).
// -----------------------------------------------------------------------------
package tcu_tag_dispatch_pkg;

  localparam int DEF_NUM_PORTS = 4;
  localparam int DEF_TAG_W     = 32;
  localparam int SLOT_PORT_W   = $clog2(DEF_NUM_PORTS);
  localparam int STAT_CNT_W    = 16;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } state_e;

  typedef struct packed {
    logic [SLOT_PORT_W-1:0] port;
    logic [DEF_TAG_W-1:0]   tag;
    logic                   eop;
  } slot_t;

  function automatic int credit_width(input int credit_max);
    return $clog2(credit_max + 1);
  endfunction

endpackage

// File: rtl/tcu_tag_dispatch_rr.sv
// -----------------------------------------------------------------------------
// tcu_tag_dispatch_rr
// Circular priority-scan arbiter: grants the first requester at or after ptr,
// wrapping around. Purely combinational.
// Ports:
//   req [NUM_PORTS]  request vector
//   ptr [PTR_W]      scan start position
//   gnt [NUM_PORTS]  one-hot grant (all zero when no request)
// -----------------------------------------------------------------------------
module tcu_tag_dispatch_rr #(
  parameter int NUM_PORTS = 4,
  parameter int PTR_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PTR_W-1:0]     ptr,
  output logic [NUM_PORTS-1:0] gnt
);

  always_comb begin
    int   idx;
    logic found;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tcu_tag_dispatch.sv
// -----------------------------------------------------------------------------
// tcu_tag_dispatch
// Egress tag dispatcher between the Tag Queuing Unit and the Transmit Controller
// Unit. Per-port credit flow control, packet-granular round-robin (tags of two
// packets never interleave), one registered output slot with valid/ready.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   tqu_valid/tag/eop    per-port tag streams from the TQU
//   tqu_ready            per-port accept (combinational from the grant, <=1 hot)
//   tcu_valid/ready      output slot handshake
//   tcu_port/tag/eop     output slot payload
//   tcu_crd_rtn          per-port one-cycle credit return pulses
//   cfg_port_en          per-port enable, sampled at packet boundaries
//   crd_err              sticky per-port credit overflow flag
//   stat_pkt_cnt         per-port saturating packet counters
//                        (only when TCU_TAG_DISPATCH_STATS_EN is defined)
// -----------------------------------------------------------------------------
module tcu_tag_dispatch
  import tcu_tag_dispatch_pkg::*;
#(
  parameter int NUM_PORTS  = DEF_NUM_PORTS,
  parameter int TAG_W      = DEF_TAG_W,
  parameter int CREDIT_MAX = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_PORTS-1:0]         tqu_valid,
  input  logic [NUM_PORTS*TAG_W-1:0]   tqu_tag,
  input  logic [NUM_PORTS-1:0]         tqu_eop,
  output logic [NUM_PORTS-1:0]         tqu_ready,
  output logic                         tcu_valid,
  input  logic                         tcu_ready,
  output logic [$clog2(NUM_PORTS)-1:0] tcu_port,
  output logic [TAG_W-1:0]             tcu_tag,
  output logic                         tcu_eop,
  input  logic [NUM_PORTS-1:0]         tcu_crd_rtn,
  input  logic [NUM_PORTS-1:0]         cfg_port_en,
  output logic [NUM_PORTS-1:0]         crd_err
`ifdef TCU_TAG_DISPATCH_STATS_EN
  ,
  output logic [NUM_PORTS*STAT_CNT_W-1:0] stat_pkt_cnt
`endif
);

  localparam int CREDIT_W = credit_width(CREDIT_MAX);
  localparam int PORT_W   = $clog2(NUM_PORTS);

  state_e               state_reg, state_next;
  logic [PORT_W-1:0]    lock_port_reg, lock_port_next;
  logic [PORT_W-1:0]    rr_ptr_reg, rr_ptr_next;
  slot_t                slot_reg;
  logic                 slot_valid_reg;

  logic                 slot_free;
  logic [NUM_PORTS-1:0] credit_nz;
  logic [NUM_PORTS-1:0] req, gnt, accept_vec;
  logic                 accept_any;
  logic [PORT_W-1:0]    winner;
  logic [TAG_W-1:0]     acc_tag;
  logic                 acc_eop;

  assign slot_free = !slot_valid_reg || tcu_ready;

  // In LOCK only the locked port may request, and its enable is ignored so a
  // packet already started always runs to its eop.
  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (state_reg == LOCK)
        req[i] = (PORT_W'(i) == lock_port_reg) && tqu_valid[i] && credit_nz[i] && slot_free;
      else
        req[i] = tqu_valid[i] && cfg_port_en[i] && credit_nz[i] && slot_free;
    end
  end

  tcu_tag_dispatch_rr #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (PORT_W)
  ) u_rr (
    .req (req),
    .ptr (rr_ptr_reg),
    .gnt (gnt)
  );

  // Ready is held low while reset is asserted so nothing is taken from the TQU.
  assign tqu_ready  = rst_n ? gnt : '0;
  assign accept_vec = tqu_ready & tqu_valid;
  assign accept_any = |accept_vec;

  always_comb begin
    winner  = '0;
    acc_tag = '0;
    acc_eop = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (gnt[i]) begin
        winner  = PORT_W'(i);
        acc_tag = tqu_tag[i*TAG_W +: TAG_W];
        acc_eop = tqu_eop[i];
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ARB;
      lock_port_reg <= '0;
      rr_ptr_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      lock_port_reg <= lock_port_next;
      rr_ptr_reg    <= rr_ptr_next;
    end
  end

  // FSM: next state. rr_ptr only moves on an eop so arbitration is per packet.
  always_comb begin
    state_next     = state_reg;
    lock_port_next = lock_port_reg;
    rr_ptr_next    = rr_ptr_reg;
    if (accept_any) begin
      if (acc_eop) begin
        state_next  = ARB;
        rr_ptr_next = (winner == PORT_W'(NUM_PORTS - 1)) ? '0 : winner + 1'b1;
      end else begin
        state_next     = LOCK;
        lock_port_next = winner;
      end
    end
  end

  // Output slot: a draining cycle may reload in the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_valid_reg <= 1'b0;
      slot_reg       <= '0;
    end else if (accept_any) begin
      slot_valid_reg <= 1'b1;
      slot_reg.port  <= winner;
      slot_reg.tag   <= acc_tag;
      slot_reg.eop   <= acc_eop;
    end else if (tcu_ready) begin
      slot_valid_reg <= 1'b0;
    end
  end

  assign tcu_valid = slot_valid_reg;
  assign tcu_port  = slot_reg.port;
  assign tcu_tag   = slot_reg.tag;
  assign tcu_eop   = slot_reg.eop;

  // Per-port credit counters. Accept and return in one cycle cancel out; a
  // return into a full pool saturates and raises the sticky error.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_credit
      logic [CREDIT_W-1:0] credit_reg;
      logic                err_reg;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          credit_reg <= CREDIT_W'(CREDIT_MAX);
          err_reg    <= 1'b0;
        end else if (accept_vec[gi] && !tcu_crd_rtn[gi]) begin
          credit_reg <= credit_reg - 1'b1;
        end else if (tcu_crd_rtn[gi] && !accept_vec[gi]) begin
          if (credit_reg == CREDIT_W'(CREDIT_MAX))
            err_reg <= 1'b1;
          else
            credit_reg <= credit_reg + 1'b1;
        end
      end

      assign credit_nz[gi] = (credit_reg != '0);
      assign crd_err[gi]   = err_reg;
    end
  endgenerate

`ifdef TCU_TAG_DISPATCH_STATS_EN
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_stats
      logic [STAT_CNT_W-1:0] pkt_cnt_reg;

      always_ff @(posedge clk) begin
        if (!rst_n)
          pkt_cnt_reg <= '0;
        else if (accept_vec[gi] && acc_eop && (pkt_cnt_reg != '1))
          pkt_cnt_reg <= pkt_cnt_reg + 1'b1;
      end

      assign stat_pkt_cnt[gi*STAT_CNT_W +: STAT_CNT_W] = pkt_cnt_reg;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_tcu_tag_dispatch.sv
// -----------------------------------------------------------------------------
// tb_tcu_tag_dispatch
// Self-checking bench for tcu_tag_dispatch (default build). A behavioural model
// holds per-port credit counts, the locked packet owner, the round-robin start
// and the output slot as plain integers, and predicts every cycle's grant and
// outputs. Directed scenarios come first, then randomized traffic.
// -----------------------------------------------------------------------------
module tb_tcu_tag_dispatch;

  localparam int N  = 4;
  localparam int TW = 32;
  localparam int CM = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    tqu_valid = '0, tqu_eop = '0, tqu_ready;
  logic [N*TW-1:0] tqu_tag = '0;
  logic            tcu_valid, tcu_ready = 1'b0, tcu_eop;
  logic [1:0]      tcu_port;
  logic [TW-1:0]   tcu_tag;
  logic [N-1:0]    tcu_crd_rtn = '0, cfg_port_en = '0, crd_err;

  tcu_tag_dispatch #(.NUM_PORTS(N), .TAG_W(TW), .CREDIT_MAX(CM)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tqu_valid   (tqu_valid),
    .tqu_tag     (tqu_tag),
    .tqu_eop     (tqu_eop),
    .tqu_ready   (tqu_ready),
    .tcu_valid   (tcu_valid),
    .tcu_ready   (tcu_ready),
    .tcu_port    (tcu_port),
    .tcu_tag     (tcu_tag),
    .tcu_eop     (tcu_eop),
    .tcu_crd_rtn (tcu_crd_rtn),
    .cfg_port_en (cfg_port_en),
    .crd_err     (crd_err)
  );

  always #5 clk = ~clk;

  // Reference model state
  int           m_cred [N];
  bit           m_err  [N];
  int           m_lock;          // -1 when no packet is in progress
  int           m_rr;
  bit           m_sv;
  int           m_sp;
  logic [TW-1:0] m_st;
  bit           m_se;
  bit           m_known = 1'b0;

  // Stimulus packet bookkeeping
  int pkt_len [N];
  int pkt_idx [N];
  bit rand_len = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < N; p++) begin
      m_cred[p]  = CM;
      m_err[p]   = 1'b0;
      pkt_idx[p] = 0;
    end
    m_lock  = -1;
    m_rr    = 0;
    m_sv    = 1'b0;
    m_sp    = 0;
    m_st    = '0;
    m_se    = 1'b0;
    m_known = 1'b1;
  endtask

  // Port the model expects to be granted with the inputs currently applied.
  function automatic int model_grant();
    int p;
    if (m_sv && !tcu_ready) return -1;
    if (m_lock >= 0)
      return (tqu_valid[m_lock] && m_cred[m_lock] > 0) ? m_lock : -1;
    for (int k = 0; k < N; k++) begin
      p = (m_rr + k) % N;
      if (tqu_valid[p] && cfg_port_en[p] && m_cred[p] > 0) return p;
    end
    return -1;
  endfunction

  // One clock cycle: apply inputs, check outputs mid-cycle, advance the model.
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] en,
                      input logic [N-1:0] rtn, input logic rdy, input logic rst);
    int           g;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_err;
    tqu_valid   = v;
    cfg_port_en = en;
    tcu_crd_rtn = rtn;
    tcu_ready   = rdy;
    rst_n       = ~rst;
    for (int p = 0; p < N; p++) begin
      tqu_eop[p]            = (pkt_idx[p] == pkt_len[p] - 1);
      tqu_tag[p*TW +: TW]   = $urandom;
    end
    #2;
    g = (rst || !m_known) ? -1 : model_grant();
    if (m_known) begin
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      exp_err = '0;
      for (int p = 0; p < N; p++) exp_err[p] = m_err[p];
      chk("tqu_ready", 64'(tqu_ready), 64'(exp_rdy));
      chk("tcu_valid", 64'(tcu_valid), 64'(m_sv));
      chk("tcu_port",  64'(tcu_port),  64'(m_sp));
      chk("tcu_tag",   64'(tcu_tag),   64'(m_st));
      chk("tcu_eop",   64'(tcu_eop),   64'(m_se));
      chk("crd_err",   64'(crd_err),   64'(exp_err));
    end
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (g >= 0) begin
        m_cred[g]--;
        m_sv = 1'b1;
        m_sp = g;
        m_st = tqu_tag[g*TW +: TW];
        m_se = tqu_eop[g];
        if (m_se) begin
          m_lock     = -1;
          m_rr       = (g + 1) % N;
          pkt_idx[g] = 0;
          if (rand_len) pkt_len[g] = $urandom_range(1, 4);
        end else begin
          m_lock = g;
          pkt_idx[g]++;
        end
      end else if (rdy) begin
        m_sv = 1'b0;
      end
      for (int p = 0; p < N; p++) begin
        if (rtn[p]) begin
          m_cred[p]++;
          if (m_cred[p] > CM) begin
            m_cred[p] = CM;
            m_err[p]  = 1'b1;
          end
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    step('0, '1, '0, 1'b1, 1'b1);
    step('0, '1, '0, 1'b1, 1'b1);
  endtask

  initial begin
    logic [N-1:0] rv, ren, rrtn;
    for (int p = 0; p < N; p++) pkt_len[p] = 1;

    // Reset and reset-state checks
    do_reset();
    step('0, '1, '0, 1'b1, 1'b0);

    // Port 0: one 3-tag packet, back to back
    pkt_len[0] = 3;
    repeat (3) step(4'b0001, '1, '0, 1'b1, 1'b0);
    repeat (2) step('0, '1, '0, 1'b1, 1'b0);

    // Ports 0 and 2 with 2-tag packets: no interleaving
    do_reset();
    pkt_len[0] = 2;
    pkt_len[2] = 2;
    repeat (6) step(4'b0101, '1, '0, 1'b1, 1'b0);
    step('0, '1, '0, 1'b1, 1'b0);

    // Port 1 exhausts its credit with single-tag packets, then one return
    do_reset();
    pkt_len[1] = 1;
    repeat (9) step(4'b0010, '1, '0, 1'b1, 1'b0);
    #1;
    chk("p1_stall_no_credit", 64'(tqu_ready[1]), 64'd0);
    step(4'b0010, '1, 4'b0010, 1'b1, 1'b0);
    step(4'b0010, '1, '0, 1'b1, 1'b0);
    step('0, '1, '0, 1'b1, 1'b0);

    // Back-pressure: slot held for 5 cycles, then streaming resumes
    do_reset();
    pkt_len[3] = 1;
    step(4'b1000, '1, '0, 1'b1, 1'b0);
    repeat (5) step(4'b1000, '1, '0, 1'b0, 1'b0);
    repeat (3) step(4'b1000, '1, '0, 1'b1, 1'b0);

    // Credit overflow on port 3, then accept and return in the same cycle
    do_reset();
    step('0, '1, 4'b1000, 1'b1, 1'b0);
    chk("crd_err3_set", 64'(crd_err[3]), 64'd1);
    step(4'b1000, '1, 4'b1000, 1'b1, 1'b0);
    repeat (3) step('0, '1, '0, 1'b1, 1'b0);
    chk("crd_err3_sticky", 64'(crd_err[3]), 64'd1);

    // Port 0 disabled mid-packet: packet completes, then no more grants
    do_reset();
    pkt_len[0] = 3;
    step(4'b0001, 4'b1111, '0, 1'b1, 1'b0);
    repeat (2) step(4'b0001, 4'b1110, '0, 1'b1, 1'b0);
    repeat (3) step(4'b0011, 4'b1110, '0, 1'b1, 1'b0);

    // Reset in the middle of a packet discards the slot
    do_reset();
    pkt_len[1] = 4;
    repeat (2) step(4'b0010, '1, '0, 1'b0, 1'b0);
    step(4'b0010, '1, '0, 1'b0, 1'b1);
    chk("rst_mid_pkt_valid", 64'(tcu_valid), 64'd0);
    repeat (4) step(4'b0010, '1, '0, 1'b1, 1'b0);

    // Randomized traffic
    rand_len = 1'b1;
    for (int p = 0; p < N; p++) pkt_len[p] = $urandom_range(1, 4);
    for (int c = 0; c < 3000; c++) begin
      rv   = 4'($urandom);
      ren  = '0;
      rrtn = '0;
      for (int p = 0; p < N; p++) begin
        ren[p]  = ($urandom_range(0, 9) != 0);
        rrtn[p] = ($urandom_range(0, 6) == 0);
      end
      step(rv, ren, rrtn, ($urandom_range(0, 3) != 0), ($urandom_range(0, 399) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
